mesh_frame_sequencer: RTL and testbench
=======================================

Name: mesh_frame_sequencer

Overview:
- Frame-level controller for the 26x18 toroidal 2-bit contour mesh.
- Accepts a raster pixel stream and assembles the 936-bit mesh input frame.
- Drives the mesh algo/high configuration, waits for the mesh pipeline to settle, then snapshots the 468-bit contour.
- Streams the contour out row by row over a valid/ready handshake.

Parameters:
- COLS, 26, mesh columns (row width of the contour output)
- ROWS, 18, mesh rows
- SETTLE, 3, clk cycles waited after the last pixel before the contour is captured; legal range 1..15

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pix_valid  in  1  pixel beat valid
- pix_ready  out  1  sequencer accepts a pixel this cycle
- pix_data  in  2  2-bit pixel value, raster order (row 0 col 0 first)
- cfg_algo  in  1  algorithm select; sampled on the first accepted pixel of a frame
- cfg_high  in  1  mesh "high" control; sampled with cfg_algo
- mesh_inp  out  COLS*ROWS*2  frame to mesh inp port
- mesh_algo  out  1  latched cfg_algo
- mesh_high  out  1  latched cfg_high
- mesh_contour  in  COLS*ROWS  contour from mesh
- row_valid  out  1  contour row beat valid
- row_ready  in  1  downstream accepts the row
- row_data  out  COLS  one contour row; MSB = column 0
- row_idx  out  5  row number of row_data, 0..ROWS-1
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse after the last row is accepted

Behaviour:
- States: IDLE, LOAD, SETTLE, CAPTURE, UNLOAD.
- Reset (any state, mid-frame included):
  - state = IDLE; all counters = 0; frame buffer = 0; contour snapshot = 0.
  - mesh_algo = 0, mesh_high = 0, pix_ready = 0, row_valid = 0, row_idx = 0, row_data = 0, busy = 0, frame_done = 0.
  - A partial frame is discarded.
- pix_ready = 1 in IDLE and LOAD only. It is registered: it goes to 1 the cycle after reset deasserts.
- A pixel is accepted when pix_valid & pix_ready.
- Pixel index k (9-bit counter, 0..467) is written to mesh_inp[935-2k : 934-2k], pixel MSB at the higher bit. mesh_inp is driven directly from the frame buffer register.
- IDLE -> LOAD on the first accepted pixel (k=0). cfg_algo and cfg_high are latched to mesh_algo and mesh_high on the same edge and held until the next frame's first pixel.
- LOAD -> SETTLE on acceptance of pixel k=467. The counter resets to 0 and pix_ready drops the next cycle.
- SETTLE lasts exactly SETTLE cycles (4-bit counter) -> CAPTURE.
- CAPTURE: one cycle; mesh_contour is registered into the snapshot -> UNLOAD.
- UNLOAD:
  - row_valid = 1; row_data = snapshot[467-26r : 442-26r]; row_idx = r.
  - r advances on row_valid & row_ready.
  - row_data and row_idx must hold stable while row_valid & !row_ready.
  - Acceptance of r=17 -> IDLE and frame_done = 1 for exactly one cycle. row_valid deasserts in that same cycle.
- Latency: first row_valid appears SETTLE+2 cycles after the edge accepting pixel 467, with row_ready held high throughout.
- With row_ready held high, 18 rows take 18 cycles.
- pix_valid pulses in SETTLE, CAPTURE or UNLOAD are ignored and the frame buffer is unchanged.
- The frame buffer is not cleared between frames; every bit is overwritten by the next full load.

Optional Feature:
- Macro: MESH_SEQ_PINGPONG_EN.
- When defined:
  - A second 936-bit buffer is added.
  - pix_ready is also 1 during UNLOAD, and the next frame loads into the inactive buffer.
  - mesh_inp keeps presenting the active buffer until the next frame's pixel 467 is accepted. On that edge, the active buffer flips.
  - If UNLOAD finishes after the next load completes, the state goes directly to SETTLE, and frame_done still pulses.
  - If the next load completes first, pix_ready = 0 until the UNLOAD -> SETTLE transition.
  - Latched cfg applies to the new buffer at its flip.
- When not defined: single buffer; behaviour exactly as above.

Test Plan:
- Reset, then 468 pixels with value 2'b11, algo=1, high=0, row_ready=1 -> mesh_inp all ones. row_valid rises SETTLE+2 = 5 cycles after the last pixel. Rows 0..17 with row_idx 0..17 are presented in 18 consecutive cycles. frame_done pulses once.
- Pixel k = k%4 pattern -> mesh_inp[935:928] = 8'b00011011. mesh_algo latched from the first beat and unchanged when cfg_algo toggles mid-frame.
- Model mesh_contour = 468'h1 (bit 0 only) -> rows 0..16 = 0 and row 17 = 26'h0000001.
- row_ready low for 4 cycles on row 5 -> row_data and row_idx=5 held stable. Row 6 is presented the cycle after ready.
- rst asserted after 200 pixels -> all outputs 0 next cycle; a fresh 468-pixel frame completes normally.
- MESH_SEQ_PINGPONG_EN, with row_ready=0 during UNLOAD while the next frame streams in:
  - mesh_inp is unchanged until pixel 467 of frame 2.
  - pix_ready = 0 after that pixel.
  - Releasing row_ready finishes frame 1; frame 2 enters SETTLE directly.

Source files
------------

// File: rtl/mesh_frame_sequencer.sv
// Frame sequencer for the 26x18 toroidal contour mesh: raster load, settle, capture, row unload.
// Defining MESH_SEQ_PINGPONG_EN adds a second frame buffer so the next frame loads during unload.
module mesh_frame_sequencer #(
  parameter int COLS   = 26,
  parameter int ROWS   = 18,
  parameter int SETTLE = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [1:0]             pix_data,
  input  logic                   cfg_algo,
  input  logic                   cfg_high,
  output logic [COLS*ROWS*2-1:0] mesh_inp,
  output logic                   mesh_algo,
  output logic                   mesh_high,
  input  logic [COLS*ROWS-1:0]   mesh_contour,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic [COLS-1:0]        row_data,
  output logic [4:0]             row_idx,
  output logic                   busy,
  output logic                   frame_done
);
  localparam int NPIX = COLS * ROWS;
  localparam int FW   = 2 * NPIX;
  localparam int IW   = $clog2(FW);
  localparam logic [8:0] LAST_PIX    = 9'(NPIX - 1);
  localparam logic [4:0] LAST_ROW    = 5'(ROWS - 1);
  localparam logic [3:0] LAST_SETTLE = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_UNLOAD  = 3'd4
  } state_t;

  state_t          state_r;
  logic [8:0]      pix_cnt_r;
  logic [3:0]      settle_cnt_r;
  logic [NPIX-1:0] snap_r;
  logic            pix_ready_r;
  logic            row_valid_r;
  logic [COLS-1:0] row_data_r;
  logic [4:0]      row_idx_r;
  logic            busy_r;
  logic            frame_done_r;
  logic            algo_r;
  logic            high_r;

  logic            accept_s;
  logic            last_pix_s;
  logic            last_row_s;
  logic [IW-1:0]   wr_lsb_s;

  assign accept_s   = pix_valid & pix_ready_r;
  assign last_pix_s = accept_s & (pix_cnt_r == LAST_PIX);
  assign last_row_s = (state_r == S_UNLOAD) & row_valid_r & row_ready & (row_idx_r == LAST_ROW);
  // Pixel 0 occupies the two most significant bits of the frame.
  assign wr_lsb_s   = IW'(FW - 2) - IW'({pix_cnt_r, 1'b0});

  // Row r of the snapshot; row 0 sits at the top bits, column 0 at the row MSB.
  function automatic logic [COLS-1:0] row_slice(input logic [NPIX-1:0] snap, input logic [4:0] r);
    logic [NPIX-1:0] sh;
    sh = snap >> (COLS * (ROWS - 1 - int'(r)));
    return sh[COLS-1:0];
  endfunction

`ifdef MESH_SEQ_PINGPONG_EN
  logic [FW-1:0] fbuf_r [2];
  logic          active_r;
  logic          load_done_r;
  logic          algo_pend_r;
  logic          high_pend_r;

  // Frame buffers: loads always target the buffer the mesh is not presenting
  always_ff @(posedge clk) begin
    if (rst) begin
      fbuf_r[0] <= '0;
      fbuf_r[1] <= '0;
    end else if (accept_s) begin
      fbuf_r[~active_r][wr_lsb_s +: 2] <= pix_data;
    end
  end

  assign mesh_inp = fbuf_r[active_r];
`else
  logic [FW-1:0] fbuf_r;

  // Frame buffer: each accepted pixel lands in its raster slot
  always_ff @(posedge clk) begin
    if (rst) begin
      fbuf_r <= '0;
    end else if (accept_s) begin
      fbuf_r[wr_lsb_s +: 2] <= pix_data;
    end
  end

  assign mesh_inp = fbuf_r;
`endif

  // Sequencer FSM with its counters and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      pix_cnt_r    <= '0;
      settle_cnt_r <= '0;
      snap_r       <= '0;
      pix_ready_r  <= 1'b0;
      row_valid_r  <= 1'b0;
      row_data_r   <= '0;
      row_idx_r    <= '0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      algo_r       <= 1'b0;
      high_r       <= 1'b0;
`ifdef MESH_SEQ_PINGPONG_EN
      active_r     <= 1'b0;
      load_done_r  <= 1'b0;
      algo_pend_r  <= 1'b0;
      high_pend_r  <= 1'b0;
`endif
    end else begin
      frame_done_r <= 1'b0;
      if (accept_s) begin
        pix_cnt_r <= (pix_cnt_r == LAST_PIX) ? 9'd0 : pix_cnt_r + 9'd1;
      end
`ifdef MESH_SEQ_PINGPONG_EN
      // Config rides with its frame and reaches the mesh when that frame becomes active.
      if (accept_s && pix_cnt_r == 9'd0) begin
        algo_pend_r <= cfg_algo;
        high_pend_r <= cfg_high;
      end
      if (last_pix_s) begin
        active_r <= ~active_r;
        algo_r   <= algo_pend_r;
        high_r   <= high_pend_r;
      end
`else
      if (accept_s && pix_cnt_r == 9'd0) begin
        algo_r <= cfg_algo;
        high_r <= cfg_high;
      end
`endif
      case (state_r)
        S_IDLE: begin
          pix_ready_r <= 1'b1;
          if (accept_s) begin
            state_r <= S_LOAD;
            busy_r  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (last_pix_s) begin
            state_r      <= S_SETTLE;
            pix_ready_r  <= 1'b0;
            settle_cnt_r <= 4'd0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt_r == LAST_SETTLE) begin
            state_r      <= S_CAPTURE;
            settle_cnt_r <= 4'd0;
          end else begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
          end
        end
        S_CAPTURE: begin
          snap_r  <= mesh_contour;
          state_r <= S_UNLOAD;
`ifdef MESH_SEQ_PINGPONG_EN
          pix_ready_r <= 1'b1;
`endif
        end
        S_UNLOAD: begin
          if (!row_valid_r) begin
            row_valid_r <= 1'b1;
            row_data_r  <= row_slice(snap_r, 5'd0);
            row_idx_r   <= 5'd0;
          end else if (row_ready) begin
            if (last_row_s) begin
              row_valid_r  <= 1'b0;
              row_data_r   <= '0;
              row_idx_r    <= 5'd0;
              frame_done_r <= 1'b1;
`ifdef MESH_SEQ_PINGPONG_EN
              if (load_done_r || last_pix_s) begin
                state_r     <= S_SETTLE;
                pix_ready_r <= 1'b0;
                load_done_r <= 1'b0;
              end else if (pix_cnt_r != 9'd0 || accept_s) begin
                state_r     <= S_LOAD;
                pix_ready_r <= 1'b1;
              end else begin
                state_r     <= S_IDLE;
                busy_r      <= 1'b0;
                pix_ready_r <= 1'b1;
              end
`else
              state_r     <= S_IDLE;
              busy_r      <= 1'b0;
              pix_ready_r <= 1'b1;
`endif
            end else begin
              row_idx_r  <= row_idx_r + 5'd1;
              row_data_r <= row_slice(snap_r, row_idx_r + 5'd1);
            end
          end
`ifdef MESH_SEQ_PINGPONG_EN
          // Next frame is complete but the current one is still draining: hold it off.
          if (last_pix_s && !last_row_s) begin
            load_done_r <= 1'b1;
            pix_ready_r <= 1'b0;
          end
`endif
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign pix_ready  = pix_ready_r;
  assign mesh_algo  = algo_r;
  assign mesh_high  = high_r;
  assign row_valid  = row_valid_r;
  assign row_data   = row_data_r;
  assign row_idx    = row_idx_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_mesh_frame_sequencer.sv
// Directed bench for mesh_frame_sequencer at default parameters (26x18 mesh, SETTLE = 3).
`timescale 1ns/1ps
module tb_mesh_frame_sequencer;
  localparam int COLS   = 26;
  localparam int ROWS   = 18;
  localparam int NPIX   = COLS * ROWS;
  localparam int FW     = 2 * NPIX;
  localparam int SETTLE = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pix_valid = 1'b0;
  logic            pix_ready;
  logic [1:0]      pix_data = 2'b00;
  logic            cfg_algo = 1'b0;
  logic            cfg_high = 1'b0;
  logic [FW-1:0]   mesh_inp;
  logic            mesh_algo;
  logic            mesh_high;
  logic [NPIX-1:0] mesh_contour = '0;
  logic            row_valid;
  logic            row_ready = 1'b1;
  logic [COLS-1:0] row_data;
  logic [4:0]      row_idx;
  logic            busy;
  logic            frame_done;

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_frame = '0;

  always #5 clk = ~clk;

  mesh_frame_sequencer #(.COLS(COLS), .ROWS(ROWS), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .cfg_algo(cfg_algo), .cfg_high(cfg_high), .mesh_inp(mesh_inp), .mesh_algo(mesh_algo),
    .mesh_high(mesh_high), .mesh_contour(mesh_contour), .row_valid(row_valid),
    .row_ready(row_ready), .row_data(row_data), .row_idx(row_idx), .busy(busy),
    .frame_done(frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] pix_val(input int mode, input int k);
    case (mode)
      0:       return 2'b11;
      1:       return 2'(k % 4);
      default: return 2'(((k * 7) + (k / 26)) % 4);
    endcase
  endfunction

  function automatic logic [NPIX-1:0] contour_pat(input int seed);
    logic [NPIX-1:0] c;
    c = '0;
    for (int r = 0; r < ROWS; r++)
      c[NPIX-1-COLS*r -: COLS] = COLS'(32'h0155_5555 ^ (seed * 32'h0000_9E37) ^ (r * 32'h0011_0101));
    return c;
  endfunction

  // Feeds pixels k_lo..k_hi, updating the expected frame; returns just after the last accepting edge.
  task automatic push_pixels(input int mode, input int k_lo, input int k_hi, input int toggle_at);
    for (int k = k_lo; k <= k_hi; k++) begin
      int w;
      w = 0;
      pix_valid = 1'b1;
      pix_data  = pix_val(mode, k);
      while (pix_ready !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      checks++;
      if (pix_ready !== 1'b1) begin
        errors++;
        $display("FAIL pix_ready_wait k=%0d got %b want 1", k, pix_ready);
      end
      exp_frame[FW-1-2*k -: 2] = pix_data;
      tick();
      if (k == toggle_at) cfg_algo = ~cfg_algo;
    end
    pix_valid = 1'b0;
  endtask

  // Counts cycles from the current point until row_valid, pulsing pix_valid while pixels must be ignored.
  task automatic wait_first_row(input int exp_lat);
    int n;
    n = 0;
    while (row_valid !== 1'b1 && n < 40) begin
      pix_valid = (n < SETTLE) ? 1'b1 : 1'b0;
      pix_data  = 2'b00;
      tick();
      n++;
    end
    pix_valid = 1'b0;
    checks++;
    if (row_valid !== 1'b1 || n != exp_lat) begin
      errors++;
      $display("FAIL first_row_latency got %0d (valid=%b) want %0d", n, row_valid, exp_lat);
    end
  endtask

  task automatic unload_rows(input int stall_row, input int stall_n);
    logic [NPIX-1:0] snap;
    logic [COLS-1:0] exp_row;
    snap = mesh_contour;
    mesh_contour = ~mesh_contour;
    row_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      exp_row = snap[NPIX-1-COLS*r -: COLS];
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 5'(r) || row_data !== exp_row) begin
        errors++;
        $display("FAIL row r=%0d got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h",
                 r, row_valid, row_idx, row_data, r, exp_row);
      end
      if (r == stall_row) begin
        row_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          checks++;
          if (row_valid !== 1'b1 || row_idx !== 5'(r) || row_data !== exp_row) begin
            errors++;
            $display("FAIL row_hold r=%0d s=%0d got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h",
                     r, s, row_valid, row_idx, row_data, r, exp_row);
          end
        end
        row_ready = 1'b1;
      end
      tick();
    end
    checks++;
    if (row_valid !== 1'b0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse got v=%b done=%b want v=0 done=1", row_valid, frame_done);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got %b want 0", frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (pix_ready !== 1'b0 || row_valid !== 1'b0 || row_idx !== 5'd0 || row_data !== '0 ||
        busy !== 1'b0 || frame_done !== 1'b0 || mesh_algo !== 1'b0 || mesh_high !== 1'b0 ||
        mesh_inp !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b idx=%0d busy=%b done=%b algo=%b high=%b want all 0",
               pix_ready, row_valid, row_idx, busy, frame_done, mesh_algo, mesh_high);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (pix_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b busy=%b want rdy=1 busy=0", pix_ready, busy);
    end
  endtask

  task automatic test_all_ones();
    cfg_algo = 1'b1;
    cfg_high = 1'b0;
    mesh_contour = contour_pat(1);
    push_pixels(0, 0, NPIX - 1, -1);
    checks++;
    if (mesh_inp !== {FW{1'b1}} || mesh_algo !== 1'b1 || mesh_high !== 1'b0) begin
      errors++;
      $display("FAIL ones_frame got algo=%b high=%b top=%h want all ones algo=1 high=0",
               mesh_algo, mesh_high, mesh_inp[FW-1 -: 32]);
    end
    checks++;
    if (pix_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL after_load got rdy=%b busy=%b want rdy=0 busy=1", pix_ready, busy);
    end
    wait_first_row(SETTLE + 2);
    checks++;
    if (mesh_inp !== exp_frame) begin
      errors++;
      $display("FAIL ignored_pixels got top=%h want top=%h", mesh_inp[FW-1 -: 32], exp_frame[FW-1 -: 32]);
    end
    unload_rows(-1, 0);
    checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL back_to_idle got busy=%b rdy=%b want busy=0 rdy=1", busy, pix_ready);
    end
  endtask

  task automatic test_pattern_cfg();
    logic [7:0] top8;
    cfg_algo = 1'b0;
    cfg_high = 1'b1;
    mesh_contour = {{(NPIX-1){1'b0}}, 1'b1};
    push_pixels(1, 0, NPIX - 1, 100);
    top8 = mesh_inp[FW-1 -: 8];
    checks++;
    if (top8 !== 8'b00011011 || mesh_inp !== exp_frame) begin
      errors++;
      $display("FAIL pattern_frame got top8=%b want 00011011 (full frame match=%b)", top8, mesh_inp === exp_frame);
    end
    checks++;
    if (mesh_algo !== 1'b0 || mesh_high !== 1'b1) begin
      errors++;
      $display("FAIL cfg_latch got algo=%b high=%b want algo=0 high=1", mesh_algo, mesh_high);
    end
    wait_first_row(SETTLE + 2);
    unload_rows(-1, 0);
  endtask

  task automatic test_row_stall();
    mesh_contour = contour_pat(7);
    push_pixels(2, 0, NPIX - 1, -1);
    wait_first_row(SETTLE + 2);
    unload_rows(5, 4);
  endtask

  task automatic test_reset_midframe();
    push_pixels(0, 0, 199, -1);
    rst = 1'b1;
    tick();
    checks++;
    if (pix_ready !== 1'b0 || row_valid !== 1'b0 || row_idx !== 5'd0 || row_data !== '0 ||
        busy !== 1'b0 || frame_done !== 1'b0 || mesh_algo !== 1'b0 || mesh_high !== 1'b0 ||
        mesh_inp !== '0) begin
      errors++;
      $display("FAIL midframe_reset got rdy=%b busy=%b algo=%b high=%b inp_zero=%b want all 0",
               pix_ready, busy, mesh_algo, mesh_high, mesh_inp === '0);
    end
    rst = 1'b0;
    exp_frame = '0;
    cfg_algo = 1'b1;
    cfg_high = 1'b1;
    mesh_contour = contour_pat(3);
    push_pixels(1, 0, NPIX - 1, -1);
    checks++;
    if (mesh_inp !== exp_frame || mesh_algo !== 1'b1 || mesh_high !== 1'b1) begin
      errors++;
      $display("FAIL fresh_frame got algo=%b high=%b top=%h want algo=1 high=1 top=%h",
               mesh_algo, mesh_high, mesh_inp[FW-1 -: 32], exp_frame[FW-1 -: 32]);
    end
    wait_first_row(SETTLE + 2);
    unload_rows(-1, 0);
  endtask

`ifdef MESH_SEQ_PINGPONG_EN
  task automatic test_pingpong();
    logic [FW-1:0] frame_a;
    cfg_algo = 1'b1;
    cfg_high = 1'b1;
    mesh_contour = contour_pat(11);
    push_pixels(1, 0, NPIX - 1, -1);
    frame_a = exp_frame;
    row_ready = 1'b0;
    wait_first_row(SETTLE + 2);
    cfg_algo = 1'b0;
    cfg_high = 1'b0;
    push_pixels(2, 0, NPIX - 2, -1);
    checks++;
    if (mesh_inp !== frame_a || mesh_algo !== 1'b1 || row_idx !== 5'd0) begin
      errors++;
      $display("FAIL pp_hold got algo=%b idx=%0d inp_match=%b want algo=1 idx=0 inp_match=1",
               mesh_algo, row_idx, mesh_inp === frame_a);
    end
    push_pixels(2, NPIX - 1, NPIX - 1, -1);
    checks++;
    if (mesh_inp !== exp_frame || mesh_algo !== 1'b0 || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL pp_flip got algo=%b rdy=%b inp_match=%b want algo=0 rdy=0 inp_match=1",
               mesh_algo, pix_ready, mesh_inp === exp_frame);
    end
    unload_rows(-1, 0);
    mesh_contour = contour_pat(12);
    checks++;
    if (busy !== 1'b1 || pix_ready !== 1'b0 || row_valid !== 1'b0) begin
      errors++;
      $display("FAIL pp_settle got busy=%b rdy=%b v=%b want busy=1 rdy=0 v=0", busy, pix_ready, row_valid);
    end
    wait_first_row(SETTLE + 1);
    unload_rows(-1, 0);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_ones();
    test_pattern_cfg();
    test_row_stall();
    test_reset_midframe();
`ifdef MESH_SEQ_PINGPONG_EN
    test_pingpong();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
